// File: rtl/imm_encoder_pkg.sv
// Shared definitions for the immediate encoder: format selects, reject causes,
// base opcodes and the buffered output word layout.
package imm_encoder_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_U = 3'b010,
        IMM_B = 3'b101,
        IMM_J = 3'b110
    } imm_src_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_BAD_SRC  = 2'b01,
        ERR_RANGE    = 2'b10,
        ERR_MISALIGN = 2'b11
    } err_code_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [31:0] ADDR_STEP = 32'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
    } out_word_t;

    // True when v[31:lsb] is all zeros or all ones, i.e. v fits a signed field below lsb+1 bits.
    function automatic logic upper_uniform(input logic [31:0] v, input int unsigned lsb);
        logic [31:0] s;
        s = 32'($signed(v) >>> lsb);
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/imm_field_packer.sv
// Combinational instruction packer: scatters the immediate and register fields
// into a 32-bit word for the selected format and classifies illegal requests.
module imm_field_packer
    import imm_encoder_pkg::*;
(
    input  logic [2:0]  imm_src,
    input  logic [31:0] imm,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic [31:0] instr,
    output err_code_e   err_code
);

    imm_src_e src;
    assign src = imm_src_e'(imm_src);

    always_comb begin
        instr      = '0;
        instr[6:0] = opcode;
        err_code   = ERR_NONE;
        case (src)
            IMM_I: begin
                instr[31:20] = imm[11:0];
                instr[19:15] = rs1;
                instr[14:12] = funct3;
                instr[11:7]  = rd;
                if (!upper_uniform(imm, 11)) err_code = ERR_RANGE;
            end
            IMM_S: begin
                instr[31:25] = imm[11:5];
                instr[24:20] = rs2;
                instr[19:15] = rs1;
                instr[14:12] = funct3;
                instr[11:7]  = imm[4:0];
                if (!upper_uniform(imm, 11)) err_code = ERR_RANGE;
            end
            IMM_B: begin
                instr[31]    = imm[12];
                instr[30:25] = imm[10:5];
                instr[24:20] = rs2;
                instr[19:15] = rs1;
                instr[14:12] = funct3;
                instr[11:8]  = imm[4:1];
                instr[7]     = imm[11];
                // Range outranks misalignment when both apply.
                if (!upper_uniform(imm, 12)) err_code = ERR_RANGE;
                else if (imm[0])             err_code = ERR_MISALIGN;
            end
            IMM_U: begin
                instr[31:12] = imm[31:12];
                instr[11:7]  = rd;
                if (imm[11:0] != '0) err_code = ERR_RANGE;
            end
            IMM_J: begin
                instr[31]    = imm[20];
                instr[30:21] = imm[10:1];
                instr[20]    = imm[11];
                instr[19:12] = imm[19:12];
                instr[11:7]  = rd;
                if (!upper_uniform(imm, 20)) err_code = ERR_RANGE;
                else if (imm[0])             err_code = ERR_MISALIGN;
            end
            default: err_code = ERR_BAD_SRC;
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Instruction encoder: packs requests into words, tags them with a running address
// and delivers them through a two-entry skid buffer; rejects are counted, not emitted.
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  imm_src,
    input  logic [31:0] imm,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic [31:0] out_addr,
    output logic        err_valid,
    output logic [1:0]  err_code,
    output logic [7:0]  err_count
);

    localparam int DEPTH = 2;

    logic [31:0] packed_instr;
    err_code_e   packed_err;

    imm_field_packer u_packer (
        .imm_src  (imm_src),
        .imm      (imm),
        .opcode   (opcode),
        .funct3   (funct3),
        .rd       (rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .instr    (packed_instr),
        .err_code (packed_err)
    );

    logic [1:0]  count_reg, count_next;
    logic [31:0] addr_reg, addr_next;
    logic        err_valid_reg, err_valid_next;
    err_code_e   err_code_reg, err_code_next;
    logic [7:0]  err_count_reg, err_count_next;

    logic        accept, push, reject, pop;
    logic [1:0]  wr_slot;
    out_word_t   new_word;

    assign in_ready = !rst && (count_reg != 2'(DEPTH));
    assign accept   = in_valid && in_ready;
    assign push     = accept && (packed_err == ERR_NONE);
    assign reject   = accept && (packed_err != ERR_NONE);
    assign pop      = out_valid && out_ready;
    // A pop shifts the skid entry down first, so the new word lands one slot lower.
    assign wr_slot  = count_reg - {1'b0, pop};
    assign new_word = {packed_instr, addr_reg};

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        out_word_t word_reg, word_next, shift_src;

        if (gi < DEPTH - 1) begin : g_shift
            assign shift_src = g_entry[gi + 1].word_reg;
        end else begin : g_hold
            assign shift_src = word_reg;
        end

        always_comb begin
            word_next = pop ? shift_src : word_reg;
            if (push && (wr_slot == 2'(gi))) word_next = new_word;
        end

        always_ff @(posedge clk) begin
            word_reg <= word_next;
        end
    end

    always_comb begin
        count_next = count_reg;
        if (push && !pop)      count_next = count_reg + 2'd1;
        else if (pop && !push) count_next = count_reg - 2'd1;

        addr_next      = push ? addr_reg + ADDR_STEP : addr_reg;
        err_valid_next = reject;
        err_code_next  = reject ? packed_err : ERR_NONE;
        err_count_next = err_count_reg;
        if (reject && (err_count_reg != 8'hFF)) err_count_next = err_count_reg + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg     <= '0;
            addr_reg      <= BASE_ADDR;
            err_valid_reg <= 1'b0;
            err_code_reg  <= ERR_NONE;
            err_count_reg <= '0;
        end else begin
            count_reg     <= count_next;
            addr_reg      <= addr_next;
            err_valid_reg <= err_valid_next;
            err_code_reg  <= err_code_next;
            err_count_reg <= err_count_next;
        end
    end

    assign out_valid = (count_reg != 2'd0);
    assign instr     = g_entry[0].word_reg.instr;
    assign out_addr  = g_entry[0].word_reg.addr;
    assign err_valid = err_valid_reg;
    assign err_code  = err_code_reg;
    assign err_count = err_count_reg;

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the start address assigned to the first emitted instruction word.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: the request fields are valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-006 SHALL have port imm_src, input, 3 bits: format select; I=000, S=001, B=101, U=010, J=110.
REQ-007 SHALL have port imm, input, 32 bits: the signed immediate (U format: the full 32-bit upper value).
REQ-008 SHALL have ports opcode (7 bits), funct3 (3 bits), rd/rs1/rs2 (5 bits each), all inputs: the non-immediate instruction fields.
REQ-009 SHALL have port out_valid, output, 1 bit: instr and out_addr are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the output word.
REQ-011 SHALL have port instr, output, 32 bits: the encoded instruction word.
REQ-012 SHALL have port out_addr, output, 32 bits: the address tag of instr.
REQ-013 SHALL have ports err_valid (1 bit) and err_code (2 bits), outputs: the reject pulse and its cause; 00 none, 01 bad imm_src, 10 out of range, 11 misaligned.
REQ-014 SHALL have port err_count, output, 8 bits: the saturating count of rejected requests.

Function
REQ-015 SHALL accept a request when in_valid && in_ready on a rising edge.
REQ-016 SHALL place the encoding in instr[6:0] = opcode.
- I: instr[31:20] = imm[11:0].
- S: instr[31:25] = imm[11:5]; instr[11:7] = imm[4:0].
- B: instr[31] = imm[12]; instr[30:25] = imm[10:5]; instr[11:8] = imm[4:1]; instr[7] = imm[11].
- U: instr[31:12] = imm[31:12].
- J: instr[31] = imm[20]; instr[30:21] = imm[10:1]; instr[20] = imm[11]; instr[19:12] = imm[19:12].
REQ-017 SHALL place the register and function fields per format, with unused bits zero.
- rd → [11:7] for I, U and J.
- rs1 → [19:15] for I, S and B.
- rs2 → [24:20] for S and B.
- funct3 → [14:12] for I, S and B.
REQ-018 SHALL reject a request with err_code 10 when the immediate is out of range.
- I and S: imm[31:11] not all equal.
- B: imm[31:12] not all equal.
- J: imm[31:20] not all equal.
- U: imm[11:0] ≠ 0.
REQ-019 SHALL reject a request with err_code 11 for B or J when imm[0] = 1; a range violation takes priority over misalignment.
REQ-020 SHALL reject a request with err_code 01 for any imm_src not listed in REQ-006.
REQ-021 SHALL consume a rejected request: no output word, no address increment, err_valid high for exactly the cycle after acceptance, err_count +1 saturating at 255.
REQ-022 SHALL give a good request 1-cycle latency: the request is accepted at edge N and out_valid is high after edge N.
REQ-023 SHALL buffer output in a 2-entry skid buffer (main + skid).
- in_ready = !skid_full.
- An output transfer on out_valid && out_ready pops the main entry.
- Simultaneous accept and pop keeps occupancy unchanged.
- Order is strictly FIFO.
REQ-024 SHALL hold instr/out_addr stable while out_valid && !out_ready.
REQ-025 SHALL tag each good request with the current address counter, then add 4; the counter wraps modulo 2^32 without error.
REQ-026 SHALL sustain 1 word/cycle throughput when out_ready is held high.

Reset
REQ-027 SHALL, while rst is high at an edge, drive out_valid=0, err_valid=0, err_code=00, err_count=0, the address counter=BASE_ADDR, and both buffer entries empty.
REQ-028 SHALL assert in_ready=0 during reset and assert it in the first cycle after reset deasserts.
REQ-029 SHALL discard any request or buffered word present when reset occurs mid-operation; no partial word is emitted afterwards.

Structure
REQ-030 SHALL define, in a shared package, the imm_src format encodings (REQ-006) as an enum, the err_code values, and the opcode constants; the immediate generator uses the same package.
REQ-031 SHALL contain one combinational sub-module, imm_field_packer, producing the packed word and err_code; the skid buffer, address counter and error counter remain in imm_encoder.

Verification
REQ-032 SHALL cover: I request, opcode 0010011, rd=1, rs1=0, funct3=000, imm=5, after reset → instr=0x00500093, out_addr=BASE_ADDR, 1 cycle later.
REQ-033 SHALL cover: back-to-back requests with out_ready=1.
- S, opcode 0100011, rs1=1, rs2=2, funct3=010, imm=8 → 0x0020A423.
- B, opcode 1100011, rs1=1, rs2=2, funct3=000, imm=-4 → 0xFE208EE3.
- J, opcode 1101111, rd=1, imm=8 → 0x008000EF.
- U, opcode 0110111, rd=5, imm=0x12345000 → 0x123452B7.
- out_addr increments by 4 per word.
REQ-034 SHALL cover the reject cases.
- I with imm=2048 → err_code=10.
- B with imm=3 → err_code=11.
- imm_src=111 → err_code=01.
- In all three cases: no out_valid, out_addr unchanged, err_count=3.
REQ-035 SHALL cover: out_ready=0 while 3 requests are offered → two accepted, then in_ready=0; out_ready=1 → words emerge in order and the third request is then accepted.
REQ-036 SHALL cover: rst asserted with 2 words buffered → out_valid=0 next cycle, out_addr restarts at BASE_ADDR.
REQ-037 SHALL cover: BASE_ADDR=0xFFFFFFFC with two good requests → out_addr values 0xFFFFFFFC then 0x00000000.
